// File: rtl/ncl_pkg.sv
// Shared NCL definitions: rail encodings and the C-element next-state rule.
package ncl_pkg;

    localparam logic NCL_NULL = 1'b0;
    localparam logic NCL_DATA = 1'b1;

    // Output sets when both inputs are DATA, clears when both are NULL,
    // and holds otherwise.
    function automatic logic th22_next(input logic a, input logic b, input logic y);
        return (a & b) | (y & (a | b));
    endfunction

endpackage

// File: rtl/ncl_th22_cell.sv
// One-bit registered C-element (TH22) with an optional synchronous NULL-clear.
// With init tied low this cell is a plain TH22; wired to the bank init it is TH22N.
module ncl_th22_cell
    import ncl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic a,
    input  logic b,
    output logic y
);

    logic y_d;
    logic y_q;

    // Next state: init forces NULL ahead of any DATA on the inputs.
    always_comb begin
        y_d = th22_next(a, b, y_q);
        if (init) y_d = NCL_NULL;
    end

    // State flop; reset leaves the gate holding NULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= NCL_NULL;
        else        y_q <= y_d;
    end

    assign y = y_q;

endmodule

// File: rtl/ncl_th_gate_bank.sv
// Bank of WIDTH independent NCL gate lanes: TH12, TH22 and TH22N, plus
// registered DATA/NULL completion flags that line up with th22_y.
module ncl_th_gate_bank
    import ncl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] th12_y,
    output logic [WIDTH-1:0] th22_y,
    output logic [WIDTH-1:0] th22n_y,
    output logic             th22_all1,
    output logic             th22_all0
);

    logic [WIDTH-1:0] th12_d, th12_q;
    logic [WIDTH-1:0] th22_nxt;
    logic             all1_d, all1_q;
    logic             all0_d, all0_q;

    // TH22 and TH22N lanes; TH22 never sees init.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ncl_th22_cell u_th22 (
            .clk   (clk),
            .rst_n (rst_n),
            .init  (1'b0),
            .a     (a[i]),
            .b     (b[i]),
            .y     (th22_y[i])
        );
        ncl_th22_cell u_th22n (
            .clk   (clk),
            .rst_n (rst_n),
            .init  (init),
            .a     (a[i]),
            .b     (b[i]),
            .y     (th22n_y[i])
        );
    end

    // Completion is taken from the value about to load into th22_y, so the
    // flags are coincident with the TH22 state rather than a cycle late.
    always_comb begin
        th12_d = a | b;
        for (int i = 0; i < WIDTH; i++)
            th22_nxt[i] = th22_next(a[i], b[i], th22_y[i]);
        all1_d = &th22_nxt;
        all0_d = ~|th22_nxt;
    end

    // TH12 lanes and completion flags; reset state means "all NULL".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th12_q <= '0;
            all1_q <= 1'b0;
            all0_q <= 1'b1;
        end else begin
            th12_q <= th12_d;
            all1_q <= all1_d;
            all0_q <= all0_d;
        end
    end

    assign th12_y    = th12_q;
    assign th22_all1 = all1_q;
    assign th22_all0 = all0_q;

endmodule

// File: tb/tb_ncl_th_gate_bank.sv
// Self-checking bench for ncl_th_gate_bank: directed scenarios plus a
// randomized run against a vector-level model of the gate rules.
module tb_ncl_th_gate_bank;

    localparam int W = 32;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init;
    logic [W-1:0] a, b;
    logic [W-1:0] th12_y, th22_y, th22n_y;
    logic         th22_all1, th22_all0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: a lane rises when both inputs are 1, falls when both are 0.
    logic [W-1:0] m22  = '0;
    logic [W-1:0] m22n = '0;

    ncl_th_gate_bank #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .a         (a),
        .b         (b),
        .th12_y    (th12_y),
        .th22_y    (th22_y),
        .th22n_y   (th22n_y),
        .th22_all1 (th22_all1),
        .th22_all0 (th22_all0)
    );

    always #5 clk = ~clk;

    // Apply inputs, let one posedge pass, advance the model; outputs sampled 1 time unit later.
    task automatic cyc(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ii);
        logic [W-1:0] rise, keep;
        a = ai; b = bi; init = ii;
        @(posedge clk);
        #1;
        rise = ai & bi;
        keep = ai | bi;
        if (rst_n) begin
            m22  = (m22 | rise) & keep;
            m22n = ii ? '0 : ((m22n | rise) & keep);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = ONES; b = ONES; init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m22 = '0; m22n = '0;
        n_chk += 5;
        if (th12_y !== '0)     begin n_fail++; $display("FAIL rst_th12 got %h want 0", th12_y); end
        if (th22_y !== '0)     begin n_fail++; $display("FAIL rst_th22 got %h want 0", th22_y); end
        if (th22n_y !== '0)    begin n_fail++; $display("FAIL rst_th22n got %h want 0", th22n_y); end
        if (th22_all1 !== 1'b0) begin n_fail++; $display("FAIL rst_all1 got %b want 0", th22_all1); end
        if (th22_all0 !== 1'b1) begin n_fail++; $display("FAIL rst_all0 got %b want 1", th22_all0); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(ONES, ONES, 1'b0);
        n_chk += 5;
        if (th12_y !== ONES)   begin n_fail++; $display("FAIL rel_th12 got %h want %h", th12_y, ONES); end
        if (th22_y !== ONES)   begin n_fail++; $display("FAIL rel_th22 got %h want %h", th22_y, ONES); end
        if (th22n_y !== ONES)  begin n_fail++; $display("FAIL rel_th22n got %h want %h", th22n_y, ONES); end
        if (th22_all1 !== 1'b1) begin n_fail++; $display("FAIL rel_all1 got %b want 1", th22_all1); end
        if (th22_all0 !== 1'b0) begin n_fail++; $display("FAIL rel_all0 got %b want 0", th22_all0); end
    endtask

    task automatic test_hysteresis();
        cyc(ONES, ONES, 1'b0);
        n_chk += 1;
        if (th22_y !== ONES) begin n_fail++; $display("FAIL hys_set got %h want %h", th22_y, ONES); end
        cyc(32'hFFFF0000, 32'h0000FFFF, 1'b0);
        n_chk += 3;
        if (th22_y !== ONES)    begin n_fail++; $display("FAIL hys_hold got %h want %h", th22_y, ONES); end
        if (th12_y !== ONES)    begin n_fail++; $display("FAIL hys_th12 got %h want %h", th12_y, ONES); end
        if (th22_all1 !== 1'b1) begin n_fail++; $display("FAIL hys_all1 got %b want 1", th22_all1); end
        cyc('0, '0, 1'b0);
        n_chk += 4;
        if (th22_y !== '0)      begin n_fail++; $display("FAIL hys_clr got %h want 0", th22_y); end
        if (th22_all0 !== 1'b1) begin n_fail++; $display("FAIL hys_all0 got %b want 1", th22_all0); end
        if (th22_all1 !== 1'b0) begin n_fail++; $display("FAIL hys_all1_lo got %b want 0", th22_all1); end
        if (th12_y !== '0)      begin n_fail++; $display("FAIL hys_th12_lo got %h want 0", th12_y); end
    endtask

    task automatic test_init_priority();
        cyc(ONES, ONES, 1'b1);
        n_chk += 2;
        if (th22n_y !== '0)  begin n_fail++; $display("FAIL init_th22n got %h want 0", th22n_y); end
        if (th22_y !== ONES) begin n_fail++; $display("FAIL init_th22 got %h want %h", th22_y, ONES); end
        cyc(ONES, ONES, 1'b0);
        n_chk += 1;
        if (th22n_y !== ONES) begin n_fail++; $display("FAIL init_drop got %h want %h", th22n_y, ONES); end
    endtask

    task automatic test_mixed();
        cyc('0, '0, 1'b0);
        cyc(32'h3, 32'h5, 1'b0);
        n_chk += 5;
        if (th22_y !== 32'h1)   begin n_fail++; $display("FAIL mix_th22 got %h want 00000001", th22_y); end
        if (th22n_y !== 32'h1)  begin n_fail++; $display("FAIL mix_th22n got %h want 00000001", th22n_y); end
        if (th12_y !== 32'h7)   begin n_fail++; $display("FAIL mix_th12 got %h want 00000007", th12_y); end
        if (th22_all1 !== 1'b0) begin n_fail++; $display("FAIL mix_all1 got %b want 0", th22_all1); end
        if (th22_all0 !== 1'b0) begin n_fail++; $display("FAIL mix_all0 got %b want 0", th22_all0); end
    endtask

    task automatic test_async_reset();
        cyc(ONES, ONES, 1'b0);
        n_chk += 1;
        if (th22_y !== ONES) begin n_fail++; $display("FAIL ar_pre got %h want %h", th22_y, ONES); end
        #2;
        rst_n = 1'b0;
        #1;
        m22 = '0; m22n = '0;
        n_chk += 5;
        if (th12_y !== '0)      begin n_fail++; $display("FAIL ar_th12 got %h want 0", th12_y); end
        if (th22_y !== '0)      begin n_fail++; $display("FAIL ar_th22 got %h want 0", th22_y); end
        if (th22n_y !== '0)     begin n_fail++; $display("FAIL ar_th22n got %h want 0", th22n_y); end
        if (th22_all1 !== 1'b0) begin n_fail++; $display("FAIL ar_all1 got %b want 0", th22_all1); end
        if (th22_all0 !== 1'b1) begin n_fail++; $display("FAIL ar_all0 got %b want 1", th22_all0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         ri;
        int           mode;
        int           shown = 0;
        int           bad;
        for (int i = 0; i < 10000; i++) begin
            mode = $urandom_range(0, 7);
            ra = $urandom;
            rb = $urandom;
            case (mode)
                0: begin ra = ONES; rb = ONES; end
                1: begin ra = '0;   rb = '0;   end
                2: rb = ra;
                default: ;
            endcase
            ri = ($urandom_range(0, 7) == 0);
            cyc(ra, rb, ri);
            bad = n_fail;
            n_chk += 6;
            if (th12_y !== (ra | rb))    n_fail++;
            if (th22_y !== m22)          n_fail++;
            if (th22n_y !== m22n)        n_fail++;
            if (th22_all1 !== (&m22))    n_fail++;
            if (th22_all0 !== (~|m22))   n_fail++;
            if (th22_all1 && th22_all0)  n_fail++;
            if (n_fail != bad && shown < 20) begin
                shown++;
                $display("FAIL rand cyc %0d th12 %h/%h th22 %h/%h th22n %h/%h all1 %b/%b all0 %b/%b",
                         i, th12_y, ra | rb, th22_y, m22, th22n_y, m22n,
                         th22_all1, &m22, th22_all0, ~|m22);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hysteresis();
        test_init_priority();
        test_mixed();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
